// File: rtl/word64_stream_fifo.sv
// word64_stream_fifo: SRAM-backed streaming FIFO with a 2-entry output skid buffer
module word64_stream_fifo #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int LANES  = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W+1:0] level,
    output logic [ADDR_W-1:0] sram_A,
    output logic [LANES-1:0]  sram_WEAN,
    output logic              sram_OEA,
    output logic [DATA_W-1:0] sram_DIA,
    output logic [ADDR_W-1:0] sram_B,
    output logic [LANES-1:0]  sram_WEBN,
    output logic              sram_OEB,
    output logic [DATA_W-1:0] sram_DIB,
    input  logic [DATA_W-1:0] sram_DOB
);
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   sram_cnt, cnt_nx;
    logic [ADDR_W+1:0] level_nx;
    logic [1:0]        skid_cnt, skid_nx, keep;
    logic [DATA_W-1:0] head, tail;
    logic              rd_inflight, push, pop, rd_issue;

    assign in_ready  = sram_cnt != (ADDR_W+1)'(DEPTH);
    assign out_valid = skid_cnt != 2'd0;
    assign out_data  = head;
    assign sram_A    = wr_ptr;
    assign sram_WEAN = {LANES{~(push & RSTN)}};
    assign sram_OEA  = 1'b0;
    assign sram_DIA  = in_data;
    assign sram_B    = rd_ptr;
    assign sram_WEBN = {LANES{1'b1}};
    assign sram_OEB  = rd_issue;
    assign sram_DIB  = '0;

    // handshakes and next-state counts; a read returning this cycle lands at skid slot 'keep'
    always_comb begin
        push     = in_valid & in_ready & ~flush;
        rd_issue = (sram_cnt != '0) & ((skid_cnt + {1'b0, rd_inflight}) < 2'd2) & ~flush;
        pop      = out_valid & out_ready & ~flush;
        keep     = skid_cnt - {1'b0, pop};
        cnt_nx   = sram_cnt + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, rd_issue};
        skid_nx  = keep + {1'b0, rd_inflight};
        level_nx = {1'b0, cnt_nx} + {{(ADDR_W+1){1'b0}}, rd_issue} + {{ADDR_W{1'b0}}, skid_nx};
    end

    // SRAM pointers, occupancy, read-in-flight flag and registered level
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
            level       <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
            level       <= '0;
        end else begin
            wr_ptr      <= wr_ptr + {{(ADDR_W-1){1'b0}}, push};
            rd_ptr      <= rd_ptr + {{(ADDR_W-1){1'b0}}, rd_issue};
            sram_cnt    <= cnt_nx;
            rd_inflight <= rd_issue;
            level       <= level_nx;
        end
    end

    // skid buffer: pop shifts tail into head, returning read data fills the first free slot
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
        end else begin
            head     <= (rd_inflight && keep == 2'd0) ? sram_DOB : pop ? tail : head;
            tail     <= (rd_inflight && keep == 2'd1) ? sram_DOB : tail;
            skid_cnt <= skid_nx;
        end
    end
endmodule

// File: tb/tb_word64_stream_fifo.sv
// tb_word64_stream_fifo: scoreboard bench for the SRAM-backed streaming FIFO
module tb_word64_stream_fifo;
    logic         CK = 1'b0, RSTN = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0, out_data, sram_DIA, sram_DIB, sram_DOB;
    logic         in_ready, out_valid, sram_OEA, sram_OEB;
    logic [7:0]   level, sram_WEAN, sram_WEBN;
    logic [5:0]   sram_A, sram_B;
    logic [127:0] mem [64];
    logic [127:0] q [$];
    logic         acc;
    int           total = 0, passed = 0, wr_wraps = 0, rd_wraps = 0, n;

    word64_stream_fifo dut (
        .CK(CK), .RSTN(RSTN), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .sram_A(sram_A), .sram_WEAN(sram_WEAN), .sram_OEA(sram_OEA),
        .sram_DIA(sram_DIA), .sram_B(sram_B), .sram_WEBN(sram_WEBN), .sram_OEB(sram_OEB),
        .sram_DIB(sram_DIB), .sram_DOB(sram_DOB)
    );

    always #5 CK = ~CK;

    // dual-port SRAM model: synchronous write on A, registered read on B
    always @(posedge CK) begin
        if (sram_WEAN == 8'h00) mem[sram_A] <= sram_DIA;
        if (sram_OEB) sram_DOB <= mem[sram_B];
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [127:0] pat(input int i);
        return {4{32'(i) ^ 32'h5A00_0000}};
    endfunction

    task automatic cyc(input logic v, input logic [127:0] d, input logic r, input logic f);
        @(posedge CK);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc       = v && in_ready && !f;
        if (f) q.delete();
        else if (acc) q.push_back(d);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (q.size() != 0 || level != 0); i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check({tag, "_q_empty"}, 128'(q.size()), 128'(0));
        check({tag, "_level"}, 128'(level), 128'(0));
    endtask

    // monitor: pops expected lines on every accepted output, watches port collisions and wraps
    always @(negedge CK) begin
        if (RSTN) begin
            if (sram_WEAN != 8'hFF && sram_OEB) check("port_collision", 128'(sram_A == sram_B), 128'(0));
            if (sram_WEAN == 8'h00 && sram_A == 6'd63) wr_wraps++;
            if (sram_OEB && sram_B == 6'd63) rd_wraps++;
            if (!flush && out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 128'(1), 128'(0));
                else check("out_data", out_data, q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        #1;
        RSTN = 1'b0;
        in_valid = 1'b1;
        #2;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_level", 128'(level), 128'(0));
        check("rst_wean", 128'(sram_WEAN), 128'(8'hFF));
        check("rst_oeb", 128'(sram_OEB), 128'(0));
        check("rst_addr", 128'({sram_A, sram_B}), 128'(0));
        @(negedge CK);
        RSTN = 1'b1;
        in_valid = 1'b0;
        // single line through an empty FIFO: visible two edges after the push
        cyc(1'b1, {16{8'hA5}}, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_level_a", 128'(level), 128'(1));
        check("t1_valid_a", 128'(out_valid), 128'(0));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_level_b", 128'(level), 128'(1));
        check("t1_valid_b", 128'(out_valid), 128'(0));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_valid_c", 128'(out_valid), 128'(1));
        check("t1_data_c", out_data, {16{8'hA5}});
        check("t1_level_c", 128'(level), 128'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_level_d", 128'(level), 128'(0));
        check("t1_valid_d", 128'(out_valid), 128'(0));
        // backpressure fill: 64 in SRAM plus 2 in skid
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, pat(n), 1'b0, 1'b0);
            if (acc) n++;
        end
        check("t2_accepted", 128'(n), 128'(66));
        check("t2_in_ready", 128'(in_ready), 128'(0));
        check("t2_level", 128'(level), 128'(66));
        drain("t2");
        // 200 lines streaming with toggling out_ready; pointers wrap several times
        wr_wraps = 0;
        rd_wraps = 0;
        n = 0;
        for (int i = 0; i < 1000 && n < 200; i++) begin
            cyc(1'b1, pat(1000 + n), i[0], 1'b0);
            if (acc) n++;
        end
        drain("t3");
        check("t3_count", 128'(n), 128'(200));
        check("t3_wr_wraps", 128'(wr_wraps >= 3), 128'(1));
        check("t3_rd_wraps", 128'(rd_wraps >= 3), 128'(1));
        // flush with 10 lines held and a read in flight
        for (int i = 0; i < 11; i++) cyc(1'b1, pat(2000 + i), 1'b0, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
        check("t4_pre_level", 128'(level), 128'(11));
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t4_read_issue", 128'(sram_OEB), 128'(1));
        cyc(1'b1, pat(9999), 1'b1, 1'b1);
        check("t4_held", 128'(level), 128'(10));
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t4_valid", 128'(out_valid), 128'(0));
        check("t4_level", 128'(level), 128'(0));
        check("t4_in_ready", 128'(in_ready), 128'(1));
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t4_discard", 128'(out_valid), 128'(0));
        cyc(1'b1, pat(3000), 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t4_post_valid", 128'(out_valid), 128'(1));
        check("t4_post_data", out_data, pat(3000));
        drain("t4");
        // asynchronous reset between edges while streaming
        for (int i = 0; i < 6; i++) cyc(1'b1, pat(4000 + i), 1'b1, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        q.delete();
        check("t5_valid", 128'(out_valid), 128'(0));
        check("t5_level", 128'(level), 128'(0));
        check("t5_in_ready", 128'(in_ready), 128'(1));
        check("t5_wean", 128'(sram_WEAN), 128'(8'hFF));
        check("t5_oeb", 128'(sram_OEB), 128'(0));
        check("t5_addr", 128'({sram_A, sram_B}), 128'(0));
        check("t5_data", out_data, 128'(0));
        @(posedge CK);
        #1;
        check("t5_wean_hold", 128'(sram_WEAN), 128'(8'hFF));
        check("t5_level_hold", 128'(level), 128'(0));
        #3;
        in_valid = 1'b0;
        RSTN = 1'b1;
        cyc(1'b1, pat(5000), 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_post_valid", 128'(out_valid), 128'(1));
        check("t5_post_data", out_data, pat(5000));
        drain("t5");
        // push and pop together at level 1
        cyc(1'b1, pat(6000), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        check("t6_level1_pre", 128'(level), 128'(1));
        check("t6_valid1_pre", 128'(out_valid), 128'(1));
        cyc(1'b1, pat(6001), 1'b1, 1'b0);
        check("t6_accept1", 128'(acc), 128'(1));
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t6_level1_post", 128'(level), 128'(1));
        drain("t6a");
        // push and pop together at level 66: push blocked, pop proceeds, order kept
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, pat(7000 + n), 1'b0, 1'b0);
            if (acc) n++;
        end
        check("t6_full_level", 128'(level), 128'(66));
        cyc(1'b1, pat(7000 + n), 1'b1, 1'b0);
        check("t6_full_block", 128'(acc), 128'(0));
        cyc(1'b1, pat(7000 + n), 1'b1, 1'b0);
        if (acc) n++;
        check("t6_full_pop", 128'(level), 128'(65));
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, pat(7000 + n), 1'b1, 1'b0);
            if (acc) n++;
        end
        drain("t6b");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
